// File: rtl/prim_stack_pkg.sv
// prim_stack_pkg: op codes, error codes and per-op decode shared by the
// Prim data/return stack engine.
//   stk_op_e   : 4-bit op code (4'hB..4'hF are illegal)
//   stk_err_e  : 2-bit sticky error code
//   op_info()  : legality, minimum depth and depth change for an op code
package prim_stack_pkg;

  typedef enum logic [3:0] {
    STK_NOP      = 4'h0,
    STK_PUSH     = 4'h1,
    STK_DROP     = 4'h2,
    STK_DUP      = 4'h3,
    STK_SWAP     = 4'h4,
    STK_OVER     = 4'h5,
    STK_NIP      = 4'h6,
    STK_ROT      = 4'h7,
    STK_NROT     = 4'h8,
    STK_REPL     = 4'h9,
    STK_REPL_POP = 4'hA
  } stk_op_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_ILLEGAL   = 2'd3
  } stk_err_e;

  // Depth change is at most one entry, so push/pop flags cover it.
  typedef struct packed {
    logic       legal;
    logic [1:0] need;
    logic       push;
    logic       pop;
  } op_info_t;

  function automatic op_info_t op_info(input logic [3:0] op);
    op_info_t r;
    r = '{legal: 1'b1, need: 2'd0, push: 1'b0, pop: 1'b0};
    case (op)
      STK_NOP:      ;
      STK_PUSH:     r.push = 1'b1;
      STK_DROP:     begin r.need = 2'd1; r.pop  = 1'b1; end
      STK_DUP:      begin r.need = 2'd1; r.push = 1'b1; end
      STK_SWAP:     r.need = 2'd2;
      STK_OVER:     begin r.need = 2'd2; r.push = 1'b1; end
      STK_NIP:      begin r.need = 2'd2; r.pop  = 1'b1; end
      STK_ROT:      r.need = 2'd3;
      STK_NROT:     r.need = 2'd3;
      STK_REPL:     r.need = 2'd1;
      STK_REPL_POP: begin r.need = 2'd2; r.pop  = 1'b1; end
      default:      r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prim_stack_ram.sv
// prim_stack_ram: spill array behind the cached T/N registers.
//   clk_i    : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (combinational read)
//   rdata_o  : read data
// Contents are intentionally not reset; the owner masks unused slots.
module prim_stack_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prim_stack.sv
// prim_stack: data/return stack engine. T and N are cached in registers,
// deeper entries spill into prim_stack_ram. One op per cycle, with depth
// tracking and sticky overflow/underflow/illegal-op reporting.
// Optional feature macro: PRIM_STACK_WATERMARK_EN (high-watermark register).
//   i_clk, i_reset_n : clock / async active-low reset
//   i_valid, i_op    : op strobe and op code
//   i_dat            : data for PUSH / REPL / REPL_POP
//   i_clr_err        : clears error state (and watermark when enabled)
//   o_t, o_n, o_third: top three entries (0 where not valid)
//   o_depth, o_empty, o_full : occupancy
//   o_err, o_err_code: sticky error flag and first error code
//   o_max_depth      : high watermark (0 when feature disabled)
module prim_stack
  import prim_stack_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  input  logic [3:0]            i_op,
  input  logic [WIDTH-1:0]      i_dat,
  input  logic                  i_clr_err,
  output logic [WIDTH-1:0]      o_t,
  output logic [WIDTH-1:0]      o_n,
  output logic [WIDTH-1:0]      o_third,
  output logic [DEPTH_LOG2+1:0] o_depth,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic [DEPTH_LOG2+1:0] o_max_depth
);

  localparam int DW = DEPTH_LOG2 + 2;
  localparam logic [DW-1:0] CAP = DW'(2**DEPTH_LOG2 + 2);
  localparam logic [DW-1:0] D2  = DW'(2);
  localparam logic [DW-1:0] D3  = DW'(3);

  logic [WIDTH-1:0]      t_q, t_d, n_q, n_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [DEPTH_LOG2-1:0] sp_q, sp_d, sp_m1;
  logic                  err_q, err_d;
  logic [1:0]            code_q, code_d;

  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [WIDTH-1:0]      wdata, ram_rd, third;
  op_info_t              info;
  logic                  rej, spill, fill;
  stk_err_e              rej_code;

  assign sp_m1 = sp_q - 1'b1;

  prim_stack_ram #(.WIDTH(WIDTH), .AW(DEPTH_LOG2)) u_ram (
    .clk_i   (i_clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (sp_m1),
    .rdata_o (ram_rd)
  );

  // Array slots below depth 3 hold stale data; present them as 0.
  assign third = (depth_q >= D3) ? ram_rd : '0;
  assign spill = (depth_q >= D2);
  assign fill  = (depth_q >= D3);

  // Legality check; an op never runs if it would under/overflow.
  always_comb begin
    info     = op_info(i_op);
    rej      = 1'b0;
    rej_code = ERR_NONE;
    if (i_valid) begin
      if (!info.legal) begin
        rej = 1'b1; rej_code = ERR_ILLEGAL;
      end else if (depth_q < DW'(info.need)) begin
        rej = 1'b1; rej_code = ERR_UNDERFLOW;
      end else if (info.push && depth_q == CAP) begin
        rej = 1'b1; rej_code = ERR_OVERFLOW;
      end
    end
  end

  // Datapath. T and N are kept at 0 when not valid, so shifting them down
  // on a pop naturally yields the "vacated slot reads as 0" behaviour.
  always_comb begin
    t_d     = t_q;
    n_d     = n_q;
    depth_d = depth_q;
    sp_d    = sp_q;
    we      = 1'b0;
    waddr   = sp_q;
    wdata   = n_q;
    if (i_valid && !rej) begin
      case (i_op)
        STK_PUSH:     begin t_d = i_dat; n_d = t_q; we = spill; end
        STK_DROP:     begin t_d = n_q;   n_d = third; end
        STK_DUP:      begin n_d = t_q;   we = spill; end
        STK_SWAP:     begin t_d = n_q;   n_d = t_q; end
        STK_OVER:     begin t_d = n_q;   n_d = t_q; we = spill; end
        STK_NIP:      n_d = third;
        // ROT/NROT rewrite the array top in place.
        STK_ROT:      begin t_d = third; n_d = t_q; we = 1'b1; waddr = sp_m1; wdata = n_q; end
        STK_NROT:     begin t_d = n_q; n_d = third; we = 1'b1; waddr = sp_m1; wdata = t_q; end
        STK_REPL:     t_d = i_dat;
        STK_REPL_POP: begin t_d = i_dat; n_d = third; end
        default:      ;
      endcase
      if (info.push) begin
        depth_d = depth_q + 1'b1;
        if (spill) sp_d = sp_q + 1'b1;
      end
      if (info.pop) begin
        depth_d = depth_q - 1'b1;
        if (fill) sp_d = sp_m1;
      end
    end
  end

  // First error wins; a clear in the same cycle as a new error lets the
  // new error's code through.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (i_clr_err) begin
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end
    if (rej) begin
      err_d = 1'b1;
      if (!err_q || i_clr_err) code_d = rej_code;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      t_q     <= '0;
      n_q     <= '0;
      depth_q <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      t_q     <= t_d;
      n_q     <= n_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

`ifdef PRIM_STACK_WATERMARK_EN
  logic [DW-1:0] max_q, max_d;

  always_comb begin
    max_d = (depth_d > max_q) ? depth_d : max_q;
    if (i_clr_err) max_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) max_q <= '0;
    else            max_q <= max_d;
  end

  assign o_max_depth = max_q;
`else
  assign o_max_depth = '0;
`endif

  assign o_t        = t_q;
  assign o_n        = n_q;
  assign o_third    = third;
  assign o_depth    = depth_q;
  assign o_empty    = (depth_q == '0);
  assign o_full     = (depth_q == CAP);
  assign o_err      = err_q;
  assign o_err_code = code_q;

endmodule

// File: tb/tb_prim_stack.sv
// tb_prim_stack: directed scenarios plus randomized ops, all checked against
// a queue-based stack model (index 0 = top).
module tb_prim_stack;
  localparam int WIDTH = 16;
  localparam int DL2   = 4;
  localparam int CAP   = 2**DL2 + 2;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic             i_valid = 1'b0;
  logic [3:0]       i_op = 4'h0;
  logic [WIDTH-1:0] i_dat = '0;
  logic             i_clr_err = 1'b0;
  logic [WIDTH-1:0] o_t, o_n, o_third;
  logic [DL2+1:0]   o_depth, o_max_depth;
  logic             o_empty, o_full, o_err;
  logic [1:0]       o_err_code;

  prim_stack #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_op(i_op),
    .i_dat(i_dat), .i_clr_err(i_clr_err), .o_t(o_t), .o_n(o_n),
    .o_third(o_third), .o_depth(o_depth), .o_empty(o_empty), .o_full(o_full),
    .o_err(o_err), .o_err_code(o_err_code), .o_max_depth(o_max_depth)
  );

  always #5 i_clk = ~i_clk;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] mq[$];
  logic             m_err = 1'b0;
  logic [1:0]       m_code = 2'd0;
  int               m_max = 0;

  int need_t [11] = '{0, 0, 1, 1, 2, 2, 2, 3, 3, 1, 2};
  int delta_t[11] = '{0, 1, -1, 1, 0, 1, -1, 0, 0, 0, -1};

  function automatic logic [WIDTH-1:0] mx(input int i);
    return (mq.size() > i) ? mq[i] : '0;
  endfunction

  task automatic model_reset();
    mq.delete(); m_err = 1'b0; m_code = 2'd0; m_max = 0;
  endtask

  task automatic model_apply(input logic v, input logic [3:0] op,
                             input logic [WIDTH-1:0] d, input logic clr);
    logic rej = 1'b0;
    logic [1:0] c = 2'd0;
    logic e0 = m_err;
    logic [WIDTH-1:0] a, b, x;
    if (v) begin
      if (op > 4'hA) begin rej = 1'b1; c = 2'd3; end
      else if (mq.size() < need_t[op]) begin rej = 1'b1; c = 2'd2; end
      else if (mq.size() + delta_t[op] > CAP) begin rej = 1'b1; c = 2'd1; end
    end
    if (v && !rej) begin
      case (op)
        4'h1: mq.push_front(d);
        4'h2: void'(mq.pop_front());
        4'h3: mq.push_front(mq[0]);
        4'h4: begin a = mq[0]; mq[0] = mq[1]; mq[1] = a; end
        4'h5: mq.push_front(mq[1]);
        4'h6: mq.delete(1);
        4'h7: begin a = mq[0]; b = mq[1]; x = mq[2]; mq[0] = x; mq[1] = a; mq[2] = b; end
        4'h8: begin a = mq[0]; b = mq[1]; x = mq[2]; mq[0] = b; mq[1] = x; mq[2] = a; end
        4'h9: mq[0] = d;
        4'hA: begin void'(mq.pop_front()); mq[0] = d; end
        default: ;
      endcase
    end
    if (clr) begin m_err = 1'b0; m_code = 2'd0; end
    if (rej) begin m_err = 1'b1; if (!e0 || clr) m_code = c; end
    if (clr) m_max = 0;
    else if (mq.size() > m_max) m_max = mq.size();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".T"},     o_t, mx(0));
    chk({tag, ".N"},     o_n, mx(1));
    chk({tag, ".third"}, o_third, mx(2));
    chk({tag, ".depth"}, o_depth, mq.size());
    chk({tag, ".empty"}, o_empty, mq.size() == 0);
    chk({tag, ".full"},  o_full, mq.size() == CAP);
    chk({tag, ".err"},   o_err, m_err);
    chk({tag, ".code"},  o_err_code, m_code);
`ifdef PRIM_STACK_WATERMARK_EN
    chk({tag, ".wm"},    o_max_depth, m_max);
`else
    chk({tag, ".wm"},    o_max_depth, 0);
`endif
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [WIDTH-1:0] d, input logic clr);
    @(negedge i_clk);
    i_valid = v; i_op = op; i_dat = d; i_clr_err = clr;
    @(posedge i_clk);
    model_apply(v, op, d, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    // 1: reset state, then underflow on empty stack
    #3;
    check_all("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    step("t1.drop", 1'b1, 4'h2, 16'h0, 1'b0);
    chk("t1.code", o_err_code, 2);
    chk("t1.depth", o_depth, 0);
    step("t1.clr", 1'b0, 4'h0, 16'h0, 1'b1);

    // 2: PUSH 1,2,3 then ROT / NROT
    for (int i = 1; i <= 3; i++) step("t2.push", 1'b1, 4'h1, 16'(i), 1'b0);
    chk("t2.third", o_third, 1);
    step("t2.rot", 1'b1, 4'h7, 16'h0, 1'b0);
    chk("t2.rotT", o_t, 1);
    chk("t2.rot3", o_third, 2);
    step("t2.nrot", 1'b1, 4'h8, 16'h0, 1'b0);
    chk("t2.nrotT", o_t, 3);
    for (int i = 0; i < 3; i++) step("t2.drop", 1'b1, 4'h2, 16'h0, 1'b0);

    // 3: fill to CAP, overflow, drain
    for (int i = 1; i <= CAP; i++) step("t3.push", 1'b1, 4'h1, 16'(i), 1'b0);
    chk("t3.full", o_full, 1);
    step("t3.ovf", 1'b1, 4'h1, 16'h55, 1'b0);
    chk("t3.code", o_err_code, 1);
    chk("t3.T", o_t, CAP);
    for (int i = CAP; i >= 1; i--) begin
      chk("t3.popT", o_t, i);
      step("t3.drop", 1'b1, 4'h2, 16'h0, 1'b0);
    end
    chk("t3.empty", o_empty, 1);
    step("t3.clr", 1'b0, 4'h0, 16'h0, 1'b1);

    // 4: REPL_POP / REPL
    step("t4.push", 1'b1, 4'h1, 16'd7, 1'b0);
    step("t4.push", 1'b1, 4'h1, 16'd5, 1'b0);
    step("t4.rp", 1'b1, 4'hA, 16'd12, 1'b0);
    chk("t4.rpT", o_t, 12);
    chk("t4.rpD", o_depth, 1);
    step("t4.repl", 1'b1, 4'h9, 16'hFFFF, 1'b0);
    chk("t4.replT", o_t, 16'hFFFF);
    step("t4.drop", 1'b1, 4'h2, 16'h0, 1'b0);

    // 5: first error wins, clear, illegal op
    for (int i = 0; i <= CAP; i++) step("t5.push", 1'b1, 4'h1, 16'(i + 100), 1'b0);
    for (int i = 0; i < CAP - 1; i++) step("t5.drop", 1'b1, 4'h2, 16'h0, 1'b0);
    step("t5.swap", 1'b1, 4'h4, 16'h0, 1'b0);
    chk("t5.sticky", o_err_code, 1);
    step("t5.clr", 1'b0, 4'h0, 16'h0, 1'b1);
    chk("t5.clrd", o_err, 0);
    step("t5.ill", 1'b1, 4'hC, 16'h0, 1'b0);
    chk("t5.ill", o_err_code, 3);
    step("t5.clrill", 1'b1, 4'h0, 16'h0, 1'b1);

    // 6: async reset at depth 5
    for (int i = 0; i < 4; i++) step("t6.push", 1'b1, 4'h1, 16'(i + 40), 1'b0);
    chk("t6.depth", o_depth, 5);
`ifdef PRIM_STACK_WATERMARK_EN
    chk("t6.wm", o_max_depth, 5);
`endif
    i_valid = 1'b1; i_op = 4'h1; i_dat = 16'hBEEF;
    #2 i_reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.rst");
    i_valid = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // random ops, biased toward pushes so deeper states get exercised
    for (int k = 0; k < 1500; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'h1;
      step("rnd", $urandom_range(0, 9) != 0, op, 16'($urandom),
           $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
